// File: rtl/sprite_mover.sv
// Horizontally moving sprite: clears the screen, draws the sprite from an external
// 1-cycle-latency ROM, and erases/redraws it on left/right commands with edge handling.
module sprite_mover #(
   parameter int SCREEN_W  = 160,
   parameter int SCREEN_H  = 120,
   parameter int SPRITE_W  = 11,
   parameter int SPRITE_H  = 10,
   parameter int X_START   = 73,
   parameter int Y_START   = 105,
   parameter int STEP      = 5,
   parameter int EDGE_MODE = 0,
   parameter int COOLDOWN  = 25000000,
   parameter int ADDR_W    = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              left,
   input  logic              right,
   input  logic [2:0]        romData,
   output logic [ADDR_W-1:0] romAddr,
   output logic [7:0]        xout,
   output logic [6:0]        yout,
   output logic [2:0]        colourOut,
   output logic              drawEn,
   output logic              ready,
   output logic              hitEdge,
   output logic [7:0]        posX
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_DRAW, S_READY, S_ERASE, S_MOVE, S_COOL, S_HALT
   } state_t;

   localparam int              NPIX  = SPRITE_W * SPRITE_H;
   localparam logic [7:0]      MAX_X = 8'(SCREEN_W - SPRITE_W);
   localparam logic [7:0]      STEPX = 8'(STEP);
   localparam logic [7:0]      X_ST  = 8'(X_START);
   localparam logic [6:0]      Y_ST  = 7'(Y_START);
   localparam logic [ADDR_W:0] K_END = (ADDR_W + 1)'(NPIX);

   state_t          r_state, w_state;
   logic [7:0]      r_pos, w_pos, r_tgt, w_tgt, r_kx, w_kx, r_x, w_x;
   logic [6:0]      r_ky, w_ky, r_y, w_y;
   logic [ADDR_W:0] r_k, w_k;
   logic [31:0]     r_cool, w_cool;
   logic            r_hit, w_hit, r_draw, w_draw, r_romsel, w_romsel;

   logic [7:0] w_xmax, w_kx_adv, w_ltgt, w_rtgt, w_cmd_tgt;
   logic [6:0] w_ymax, w_ky_adv;
   logic [8:0] w_rsum;
   logic       w_xlast, w_rlast, w_cmd_l, w_cmd_r, w_oob;

   // Shared raster counter: full screen while clearing, sprite box otherwise
   assign w_xmax   = (r_state == S_CLEAR) ? 8'(SCREEN_W - 1) : 8'(SPRITE_W - 1);
   assign w_ymax   = (r_state == S_CLEAR) ? 7'(SCREEN_H - 1) : 7'(SPRITE_H - 1);
   assign w_xlast  = (r_kx == w_xmax);
   assign w_rlast  = w_xlast && (r_ky == w_ymax);
   assign w_kx_adv = w_xlast ? 8'd0 : r_kx + 8'd1;
   assign w_ky_adv = w_xlast ? r_ky + 7'd1 : r_ky;

   assign w_cmd_l   = left & ~right;
   assign w_cmd_r   = right & ~left;
   assign w_rsum    = {1'b0, r_pos} + {1'b0, STEPX};
   assign w_ltgt    = (r_pos >= STEPX) ? r_pos - STEPX : 8'd0;
   assign w_rtgt    = (w_rsum <= {1'b0, MAX_X}) ? w_rsum[7:0] : MAX_X;
   assign w_cmd_tgt = w_cmd_l ? w_ltgt : w_rtgt;
   assign w_oob     = w_cmd_l ? (r_pos < STEPX) : (w_rsum > {1'b0, MAX_X});

   always_comb begin
      w_state  = r_state;
      w_pos    = r_pos;
      w_tgt    = r_tgt;
      w_hit    = r_hit;
      w_k      = r_k;
      w_kx     = r_kx;
      w_ky     = r_ky;
      w_cool   = r_cool;
      w_x      = r_x;
      w_y      = r_y;
      w_draw   = 1'b0;
      w_romsel = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state = S_CLEAR;
               w_kx    = '0;
               w_ky    = '0;
            end
         end
         S_CLEAR: begin
            w_draw = 1'b1;
            w_x    = r_kx;
            w_y    = r_ky;
            w_kx   = w_kx_adv;
            w_ky   = w_ky_adv;
            if (w_rlast) begin
               w_state = S_DRAW;
               w_k     = '0;
               w_kx    = '0;
               w_ky    = '0;
            end
         end
         S_DRAW, S_MOVE: begin
            // Pixel k is strobed the cycle after romAddr=k, when romData holds ROM[k]
            if (r_k == K_END) begin
               w_state = (r_state == S_DRAW) ? S_READY : S_COOL;
               w_k     = '0;
               w_kx    = '0;
               w_ky    = '0;
               w_cool  = '0;
            end else begin
               w_draw   = 1'b1;
               w_romsel = 1'b1;
               w_x      = r_pos + r_kx;
               w_y      = Y_ST + r_ky;
               w_k      = r_k + 1'b1;
               w_kx     = w_kx_adv;
               w_ky     = w_ky_adv;
            end
         end
         S_READY: begin
            if (w_cmd_l || w_cmd_r) begin
               if ((EDGE_MODE != 0) && w_oob) begin
                  w_state = S_HALT;
                  w_hit   = 1'b1;
               end else if (w_cmd_tgt == r_pos) begin
                  w_state = S_COOL;
                  w_hit   = 1'b1;
                  w_cool  = '0;
               end else begin
                  w_state = S_ERASE;
                  w_tgt   = w_cmd_tgt;
                  w_kx    = '0;
                  w_ky    = '0;
               end
            end
         end
         S_ERASE: begin
            w_draw = 1'b1;
            w_x    = r_pos + r_kx;
            w_y    = Y_ST + r_ky;
            w_kx   = w_kx_adv;
            w_ky   = w_ky_adv;
            if (w_rlast) begin
               w_state = S_MOVE;
               w_pos   = r_tgt;
               w_k     = '0;
               w_kx    = '0;
               w_ky    = '0;
            end
         end
         S_COOL: begin
            w_hit = 1'b0;
            if ((r_cool + 32'd1) >= 32'(COOLDOWN)) w_state = S_READY;
            else                                   w_cool  = r_cool + 32'd1;
         end
         S_HALT: begin
            w_hit = 1'b1;
            if (start) begin
               w_state = S_CLEAR;
               w_hit   = 1'b0;
               w_pos   = X_ST;
               w_kx    = '0;
               w_ky    = '0;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_pos    <= X_ST;
         r_tgt    <= '0;
         r_hit    <= 1'b0;
         r_k      <= '0;
         r_kx     <= '0;
         r_ky     <= '0;
         r_cool   <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_draw   <= 1'b0;
         r_romsel <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_pos    <= w_pos;
         r_tgt    <= w_tgt;
         r_hit    <= w_hit;
         r_k      <= w_k;
         r_kx     <= w_kx;
         r_ky     <= w_ky;
         r_cool   <= w_cool;
         r_x      <= w_x;
         r_y      <= w_y;
         r_draw   <= w_draw;
         r_romsel <= w_romsel;
      end
   end

   // The ROM's own output register acts as the colour register during sprite sweeps
   assign colourOut = r_romsel ? romData : 3'd0;
   assign romAddr   = r_k[ADDR_W-1:0];
   assign xout      = r_x;
   assign yout      = r_y;
   assign drawEn    = r_draw;
   assign hitEdge   = r_hit;
   assign posX      = r_pos;
   assign ready     = (r_state == S_READY);

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: a clamp-mode instance at full screen and a halt-mode instance on
// a small screen, driven by random commands and checked against a pixel-list model.
module tb_sprite_mover;

   localparam int SW   = 11;
   localparam int SH   = 10;
   localparam int NPIX = SW * SH;
   localparam int STEP = 5;
   localparam int CD   = 4;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       rst_n [2];
   logic       st [2], lf [2], rt [2];
   logic [2:0] rd [2], co [2];
   logic [6:0] ra [2], yo [2];
   logic [7:0] xo [2], px [2];
   logic       den [2], rdy [2], hit [2];
   logic [2:0] rom [128];

   pix_t obs [$];
   pix_t expq [$];
   int   mpos [2];
   bit   mhalt;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   sprite_mover #(.EDGE_MODE(0), .COOLDOWN(CD)) u_dut0 (
      .clk(clk), .reset(rst_n[0]), .start(st[0]), .left(lf[0]), .right(rt[0]),
      .romData(rd[0]), .romAddr(ra[0]), .xout(xo[0]), .yout(yo[0]), .colourOut(co[0]),
      .drawEn(den[0]), .ready(rdy[0]), .hitEdge(hit[0]), .posX(px[0]));

   sprite_mover #(.SCREEN_W(40), .SCREEN_H(24), .X_START(14), .Y_START(12),
                  .EDGE_MODE(1), .COOLDOWN(CD)) u_dut1 (
      .clk(clk), .reset(rst_n[1]), .start(st[1]), .left(lf[1]), .right(rt[1]),
      .romData(rd[1]), .romAddr(ra[1]), .xout(xo[1]), .yout(yo[1]), .colourOut(co[1]),
      .drawEn(den[1]), .ready(rdy[1]), .hitEdge(hit[1]), .posX(px[1]));

   // Synchronous ROM: data for an address appears one cycle later
   always @(posedge clk) begin
      rd[0] <= rom[ra[0]];
      rd[1] <= rom[ra[1]];
   end

   // Only one instance is active at a time, so both feed a single strobe log
   always @(negedge clk) begin
      if (den[0]) obs.push_back({xo[0], yo[0], co[0]});
      if (den[1]) obs.push_back({xo[1], yo[1], co[1]});
   end

   function automatic int scrw(input int m); return (m != 0) ? 40 : 160; endfunction
   function automatic int scrh(input int m); return (m != 0) ? 24 : 120; endfunction
   function automatic int xst(input int m);  return (m != 0) ? 14 : 73;  endfunction
   function automatic int yst(input int m);  return (m != 0) ? 12 : 105; endfunction
   function automatic int maxx(input int m); return scrw(m) - SW;        endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic add_clear(input int m);
      for (int y = 0; y < scrh(m); y++)
         for (int x = 0; x < scrw(m); x++)
            expq.push_back({8'(x), 7'(y), 3'd0});
   endtask

   task automatic add_box(input int m, input int p, input bit spr);
      pix_t e;
      for (int r = 0; r < SH; r++)
         for (int c = 0; c < SW; c++) begin
            e.x = 8'(p + c);
            e.y = 7'(yst(m) + r);
            e.c = spr ? rom[r * SW + c] : 3'd0;
            expq.push_back(e);
         end
   endtask

   task automatic cmp_stream(input string tag);
      int errs = 0;
      int n;
      check({tag, "_count"}, obs.size(), expq.size());
      n = (obs.size() < expq.size()) ? obs.size() : expq.size();
      for (int i = 0; i < n; i++)
         if (obs[i] !== expq[i]) errs++;
      check({tag, "_pixels"}, errs, 0);
      obs.delete();
      expq.delete();
   endtask

   task automatic do_start(input int m);
      int   ncyc = 0;
      int   hdr  = scrw(m) * scrh(m);
      logic [2:0] first_col;
      obs.delete();
      st[m] = 1'b1;
      do begin
         @(negedge clk);
         st[m] = 1'b0;
         if (!rdy[m]) ncyc++;
      end while (!rdy[m] && ncyc < 25000);
      check("start_ready", rdy[m], 1);
      check("start_cycles", ncyc, hdr + NPIX + 1);
      first_col = (obs.size() > hdr) ? obs[hdr].c : 3'bx;
      check("first_sprite_colour", first_col, rom[0]);
      add_clear(m);
      add_box(m, xst(m), 1'b1);
      cmp_stream("start");
      check("start_posX", px[m], xst(m));
      check("start_hitEdge", hit[m], 0);
      mpos[m] = xst(m);
      mhalt   = 1'b0;
   endtask

   // Issue one command from READY (dir 0 = left, 1 = right); hold keeps it asserted throughout
   task automatic do_cmd(input int m, input int dir, input bit hold);
      int p = mpos[m];
      int t, ncyc, gap, hc;
      bit oob;
      if (dir == 0) begin oob = (p - STEP < 0);       t = oob ? 0       : p - STEP; end
      else          begin oob = (p + STEP > maxx(m)); t = oob ? maxx(m) : p + STEP; end
      obs.delete();
      if (dir == 0) lf[m] = 1'b1; else rt[m] = 1'b1;
      ncyc = 0; gap = 0; hc = 0;
      if (m == 1 && oob) begin
         repeat (8) begin
            @(negedge clk);
            hc   += int'(hit[m]);
            ncyc += int'(rdy[m]);
         end
         lf[m] = 1'b0; rt[m] = 1'b0;
         check("halt_hitEdge", hc, 8);
         check("halt_ready", ncyc, 0);
         check("halt_strobes", obs.size(), 0);
         check("halt_posX", px[m], p);
         mhalt = 1'b1;
         return;
      end
      do begin
         @(negedge clk);
         if (!hold) begin lf[m] = 1'b0; rt[m] = 1'b0; end
         hc += int'(hit[m]);
         if (den[m]) gap = 0;
         else if (!rdy[m]) gap++;
         if (!rdy[m]) ncyc++;
      end while (!rdy[m] && ncyc < 3000);
      lf[m] = 1'b0; rt[m] = 1'b0;
      check("cmd_ready", rdy[m], 1);
      if (t == p) begin
         check("edge_hit_pulses", hc, 1);
         check("edge_cycles", ncyc, CD);
         check("edge_strobes", obs.size(), 0);
      end else begin
         check("move_hit_pulses", hc, 0);
         check("move_cycles", ncyc, 2 * NPIX + 1 + CD);
         check("move_cooldown", gap, CD);
         add_box(m, p, 1'b0);
         add_box(m, t, 1'b1);
         cmp_stream("move");
      end
      mpos[m] = t;
      check("cmd_posX", px[m], t);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc, hc, d;
      for (int i = 0; i < 128; i++) rom[i] = 3'($urandom_range(1, 7));
      for (int m = 0; m < 2; m++) begin
         rst_n[m] = 1'b0; st[m] = 1'b0; lf[m] = 1'b0; rt[m] = 1'b0;
      end
      mhalt = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_posX", px[0], 73);
      check("reset_drawEn", den[0], 0);
      check("reset_ready", rdy[0], 0);
      check("reset_hitEdge", hit[0], 0);
      check("reset_xout", xo[0], 0);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_no_strobe", obs.size(), 0);

      // Clamp-mode instance
      do_start(0);
      do_cmd(0, 1, 1'b0);
      for (int i = 0; i < 18; i++) do_cmd(0, 0, 1'b1);
      for (int i = 0; i < 32; i++) do_cmd(0, 1, 1'b1);

      obs.delete();
      lf[0] = 1'b1; rt[0] = 1'b1;
      rc = 0; hc = 0;
      repeat (100) begin
         @(negedge clk);
         rc += int'(rdy[0]);
         hc += int'(hit[0]);
      end
      lf[0] = 1'b0; rt[0] = 1'b0;
      check("both_ready", rc, 100);
      check("both_hit", hc, 0);
      check("both_strobes", obs.size(), 0);
      check("both_posX", px[0], mpos[0]);

      for (int i = 0; i < 20; i++) do_cmd(0, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Asynchronous reset in the middle of an erase
      d = (mpos[0] < maxx(0)) ? 1 : 0;
      if (d == 1) rt[0] = 1'b1; else lf[0] = 1'b1;
      repeat (50) @(negedge clk);
      lf[0] = 1'b0; rt[0] = 1'b0;
      check("erase_active", den[0], 1);
      @(posedge clk);
      #2 rst_n[0] = 1'b0;
      #1 check("reset_async_drawEn", den[0], 0);
      @(posedge clk);
      #2 rst_n[0] = 1'b1;
      @(negedge clk);
      obs.delete();
      check("rst2_posX", px[0], 73);
      check("rst2_ready", rdy[0], 0);
      check("rst2_hitEdge", hit[0], 0);
      check("rst2_xout", xo[0], 0);
      check("rst2_yout", yo[0], 0);
      check("rst2_colour", co[0], 0);
      check("rst2_romAddr", ra[0], 0);
      repeat (20) @(negedge clk);
      check("rst2_idle_strobes", obs.size(), 0);
      check("rst2_idle_ready", rdy[0], 0);

      // Halt-mode instance
      do_start(1);
      for (int i = 0; i < 3; i++) do_cmd(1, 0, 1'b0);
      check("halted_after_lefts", mhalt, 1);
      do_start(1);
      for (int i = 0; i < 14; i++) begin
         if (mhalt) do_start(1);
         do_cmd(1, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) if (!mhalt) do_cmd(1, 1, 1'b0);
      check("halted_after_rights", mhalt, 1);
      do_start(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
